// File: rtl/mem_access_unit.sv
// Memory-side sequencer between the datapath MAR/MDR ports and a single-port RAM.
// It runs one read or write per request, with a minimum wait count, a ready handshake and an abort on timeout.
module mem_access_unit #(
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [15:0] MAR_in,
  input  logic [15:0] MDR_in,
  output logic [15:0] M_bus_data,
  output logic        MMD,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DONE = 3'd2,
    WR_WAIT = 3'd3,
    WR_DONE = 3'd4,
    ABORT   = 3'd5
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        complete;
  logic        timeout;
  logic [7:0]  cnt_inc;

  // mem_ready only counts once the minimum wait has elapsed; completion outranks timeout
  assign complete = (cnt_q >= WAIT_LAST) && mem_ready;
  assign timeout  = (cnt_q >= TO_LAST);
  assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_read && req_write) begin
          state_d = ABORT;
        end else if (req_read) begin
          addr_d  = MAR_in;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end else if (req_write) begin
          addr_d  = MAR_in;
          wdata_d = MDR_in;
          cnt_d   = '0;
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_inc;
        if (complete) begin
          rdata_d = mem_rdata;
          state_d = RD_DONE;
        end else if (timeout) begin
          state_d = ABORT;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_inc;
        if (complete) begin
          state_d = WR_DONE;
        end else if (timeout) begin
          state_d = ABORT;
        end
      end
      RD_DONE, WR_DONE, ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    mem_re = (state_q == RD_WAIT);
    mem_we = (state_q == WR_WAIT);
    MMD    = (state_q == RD_DONE);
    done   = (state_q == RD_DONE) || (state_q == WR_DONE) || (state_q == ABORT);
    err    = (state_q == ABORT);
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign M_bus_data = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a scoreboard of expected transaction endings plus
// cycle-level checks on two instances (WAIT_CYCLES=1/TIMEOUT=8 and WAIT_CYCLES=3).
module tb_mem_access_unit;

  logic        CLK;
  logic        CLR;
  logic        req_read, req_write;
  logic [15:0] MAR_in, MDR_in, mem_rdata;
  logic        mem_ready;
  logic [15:0] M_bus_data, mem_addr, mem_wdata;
  logic        MMD, busy, done, err, mem_re, mem_we;

  logic        b_req_read, b_req_write, b_mem_ready;
  logic [15:0] b_M_bus_data, b_mem_addr, b_mem_wdata;
  logic        b_MMD, b_busy, b_done, b_err, b_mem_re, b_mem_we;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        mmd;
    logic        err;
    logic [15:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  mem_access_unit #(.WAIT_CYCLES(1), .TIMEOUT(8)) dut_a (
    .CLK(CLK), .CLR(CLR), .req_read(req_read), .req_write(req_write),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .M_bus_data(M_bus_data), .MMD(MMD),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_access_unit #(.WAIT_CYCLES(3), .TIMEOUT(255)) dut_b (
    .CLK(CLK), .CLR(CLR), .req_read(b_req_read), .req_write(b_req_write),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .M_bus_data(b_M_bus_data), .MMD(b_MMD),
    .busy(b_busy), .done(b_done), .err(b_err), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_re(b_mem_re), .mem_we(b_mem_we),
    .mem_rdata(mem_rdata), .mem_ready(b_mem_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic m, input logic e, input logic [15:0] d);
    exp_t x;
    x.mmd  = m;
    x.err  = e;
    x.data = d;
    sb_q.push_back(x);
  endtask

  // Every done pulse from dut_a must match the oldest expected transaction ending.
  always @(negedge CLK) begin
    if (CLR && done) begin
      n_checks++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected_done observed=%0d expected=0", 1);
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        n_checks++;
        assert ({MMD, err, M_bus_data} === {mon_e.mmd, mon_e.err, mon_e.data}) else begin
          n_err++;
          $error("FAIL sb_done observed=%h expected=%h", {MMD, err, M_bus_data},
                 {mon_e.mmd, mon_e.err, mon_e.data});
        end
      end
    end
  end

  initial begin
    CLR = 1'b0; req_read = 0; req_write = 0; MAR_in = 0; MDR_in = 0;
    mem_rdata = 0; mem_ready = 0;
    b_req_read = 0; b_req_write = 0; b_mem_ready = 1;
    tick();
    chk("reset_outs", {M_bus_data, mem_addr, mem_wdata, MMD, busy, done, err, mem_re, mem_we}, 0);
    chk("reset_outs_b", {b_M_bus_data, b_mem_addr, b_busy, b_done, b_mem_re}, 0);
    CLR = 1'b1;
    tick();

    // WAIT_CYCLES=3 with ready tied high: exactly three RD_WAIT cycles
    b_req_read = 1; MAR_in = 16'h0077; mem_rdata = 16'hC0DE;
    tick();
    b_req_read = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b_wait%0d", i), {b_mem_re, b_done, b_MMD, b_busy}, 4'b1001);
      tick();
    end
    chk("b_done", {b_MMD, b_done, b_mem_re, b_M_bus_data}, {3'b110, 16'hC0DE});
    chk("b_addr", b_mem_addr, 16'h0077);
    tick();
    chk("b_idle", {b_busy, b_done}, 2'b00);

    // Basic read, one wait cycle
    req_read = 1; MAR_in = 16'h1234; mem_rdata = 16'hBEEF; mem_ready = 1;
    push(1'b1, 1'b0, 16'hBEEF);
    tick();
    req_read = 0;
    chk("rd_wait", {mem_re, mem_we, busy, done, mem_addr}, {4'b1010, 16'h1234});
    tick();
    chk("rd_done", {MMD, done, err, busy, mem_re, M_bus_data}, {5'b11010, 16'hBEEF});
    tick();
    chk("rd_idle", {busy, done, MMD}, 3'b000);

    // Write with ready arriving on the fourth wait cycle; bus inputs change underneath
    req_write = 1; MAR_in = 16'h00C0; MDR_in = 16'h5A5A; mem_ready = 0;
    push(1'b0, 1'b0, 16'hBEEF);
    tick();
    req_write = 0; MAR_in = 16'hFFFF; MDR_in = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      chk($sformatf("wr_wait%0d", i), {mem_we, mem_re, done, mem_addr, mem_wdata},
          {3'b100, 16'h00C0, 16'h5A5A});
      tick();
    end
    mem_ready = 0;
    chk("wr_done", {done, MMD, err, mem_we, M_bus_data}, {4'b1000, 16'hBEEF});
    tick();

    // Timeout after 8 wait cycles with no ready
    req_read = 1; MAR_in = 16'h0100; mem_rdata = 16'h1111;
    push(1'b0, 1'b1, 16'hBEEF);
    tick();
    req_read = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_wait%0d", i), {mem_re, done}, 2'b10);
      tick();
    end
    chk("to_abort", {done, err, MMD, mem_re, mem_we, M_bus_data}, {5'b11000, 16'hBEEF});
    tick();

    // Ready on the last cycle before timeout: completion wins
    req_read = 1; MAR_in = 16'h0200; mem_rdata = 16'h2468;
    push(1'b1, 1'b0, 16'h2468);
    tick();
    req_read = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = (i == 7);
      tick();
    end
    mem_ready = 0;
    chk("to_edge_done", {MMD, done, err, M_bus_data}, {3'b110, 16'h2468});
    tick();

    // Both requests at once: protocol error, no memory access
    req_read = 1; req_write = 1;
    push(1'b0, 1'b1, 16'h2468);
    tick();
    req_read = 0; req_write = 0;
    chk("both_abort", {mem_re, mem_we, done, err, MMD}, 5'b00110);
    tick();

    // Requests during RD_WAIT are ignored
    req_read = 1; MAR_in = 16'h0A0A; mem_rdata = 16'h7777; mem_ready = 0;
    push(1'b1, 1'b0, 16'h7777);
    tick();
    req_read = 0; req_write = 1; MAR_in = 16'hFFFF;
    tick();
    chk("ign_addr", {mem_re, mem_we, mem_addr}, {2'b10, 16'h0A0A});
    tick();
    req_write = 0; mem_ready = 1;
    tick();
    chk("ign_done", {MMD, done, M_bus_data}, {2'b11, 16'h7777});
    mem_ready = 0;
    tick();

    // Asynchronous reset mid-write: outputs clear at once, no done follows
    req_write = 1; MAR_in = 16'h2222; MDR_in = 16'h3333;
    tick();
    req_write = 0;
    chk("rst_pre", {mem_we, mem_addr}, {1'b1, 16'h2222});
    #2 CLR = 1'b0;
    #1;
    chk("rst_async", {M_bus_data, mem_addr, mem_wdata, MMD, busy, done, err, mem_re, mem_we}, 0);
    tick();
    tick();
    CLR = 1'b1;
    tick();
    chk("rst_idle", {busy, done}, 2'b00);
    tick();

    // Normal read after reset release
    req_read = 1; MAR_in = 16'h4444; mem_rdata = 16'h5555; mem_ready = 1;
    push(1'b1, 1'b0, 16'h5555);
    tick();
    req_read = 0;
    chk("post_rst_wait", {mem_re, mem_addr}, {1'b1, 16'h4444});
    tick();
    chk("post_rst_done", {MMD, done, M_bus_data}, {2'b11, 16'h5555});
    tick();
    tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-side sequencer between the datapath's MAR/MDR ports and the external single-port RAM. It accepts one read or write request per transaction from the control unit and holds address and write data stable for the whole memory cycle. It enforces a minimum wait-state count plus a ready handshake, and aborts on timeout. On reads it returns data on M_bus_data and raises a one-cycle MMD load strobe so the datapath MDR captures it.

Parameters:
WAIT_CYCLES, 1, minimum cycles spent in a wait state before completion is allowed; legal range 1..15
TIMEOUT, 255, cycles in a wait state without completion before abort; must be greater than WAIT_CYCLES; legal range up to 255

Ports:
CLK  input  1  system clock, rising edge
CLR  input  1  reset; asynchronous, active-low
req_read  input  1  read request from control unit; sampled in IDLE only
req_write  input  1  write request from control unit; sampled in IDLE only
MAR_in  input  16  address from datapath MAR_out
MDR_in  input  16  write data from datapath M_bus_out
M_bus_data  output  16  read data to datapath M_bus_in; registered
MMD  output  1  one-cycle MDR load strobe on a successful read
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse ending any transaction, including an abort
err  output  1  one-cycle pulse, coincident with done, on abort or protocol error
mem_addr  output  16  RAM address; registered
mem_wdata  output  16  RAM write data; registered
mem_re  output  1  RAM read enable
mem_we  output  1  RAM write enable
mem_rdata  input  16  RAM read data
mem_ready  input  1  RAM completion handshake

Behaviour:
- Reset (CLR=0, asynchronous): state goes to IDLE; every output is 0, including M_bus_data, mem_addr and mem_wdata; the wait counter is cleared. Reset during a transaction drops it immediately: no done, no MMD.
- States: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE, ABORT.
- IDLE:
  - req_read=1 and req_write=0: latch mem_addr<=MAR_in, clear counter, go to RD_WAIT.
  - req_write=1 and req_read=0: latch mem_addr<=MAR_in and mem_wdata<=MDR_in, clear counter, go to WR_WAIT.
  - Both requests high: no memory access; go to ABORT. This is a protocol error.
- RD_WAIT / WR_WAIT:
  - mem_re or mem_we (respectively) is held high for the entire state; mem_addr and mem_wdata are held stable.
  - The counter increments each cycle and saturates at 255.
  - Completion condition: counter >= WAIT_CYCLES-1 and mem_ready=1. Before that count, mem_ready is ignored.
  - RD_WAIT on completion: M_bus_data<=mem_rdata, go to RD_DONE.
  - WR_WAIT on completion: go to WR_DONE.
  - If the counter reaches TIMEOUT-1 without completion: go to ABORT. If completion and timeout occur in the same cycle, completion wins.
- RD_DONE: MMD=1 and done=1 for one cycle, mem_re=0, then IDLE. M_bus_data holds the read value until the next successful read.
- WR_DONE: done=1 for one cycle, mem_we=0, then IDLE.
- ABORT: done=1 and err=1 for one cycle, then IDLE. MMD is not raised, M_bus_data is unchanged, mem_re and mem_we are 0.
- mem_re and mem_we are never high together.
- While busy=1, requests are ignored, not queued. A request still high in the cycle after done is accepted as a new transaction, because the unit is back in IDLE.
- Latency with WAIT_CYCLES=1 and mem_ready tied high: request sampled at edge k, mem_re high from edge k to edge k+1, done/MMD high between edge k+1 and edge k+2. Each additional wait cycle adds one cycle.

Test Plan:
- Read, WAIT_CYCLES=1, mem_ready=1, MAR_in=0x1234, mem_rdata=0xBEEF: mem_addr=0x1234, mem_re high 1 cycle, then MMD=done=1 for 1 cycle with M_bus_data=0xBEEF; busy high for 2 cycles.
- Write, MAR_in=0x00C0, MDR_in=0x5A5A, mem_ready delayed 3 cycles: mem_we high 4 cycles with mem_addr/mem_wdata stable, then done pulse; MMD stays 0; M_bus_data unchanged.
- WAIT_CYCLES=3, mem_ready tied 1: read completes only after 3 RD_WAIT cycles; an early mem_ready has no effect.
- Timeout, TIMEOUT=8, mem_ready=0: after 8 RD_WAIT cycles, done=err=1 for 1 cycle, no MMD, previous M_bus_data retained.
- req_read and req_write both high in IDLE: no mem_re/mem_we, done=err=1 next cycle; a new request raised during RD_WAIT is ignored.
- CLR pulsed low mid-WR_WAIT: mem_we drops immediately and all outputs read 0; no done afterwards; the next read after release proceeds normally.
